// File: rtl/sys_mem_resp.sv
// Four-phase memory responder: one access at a time, fixed latency, 2-byte writes, 1-byte reads.
// Storage is split into even/odd byte banks so a 2-byte write needs only one write port per bank.
module sys_mem_resp #(
    parameter int ADDR_W    = 14,
    parameter int READ_LAT  = 2,
    parameter int WRITE_LAT = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              read_req,
    input  logic              write_req,
    input  logic [ADDR_W-1:0] addrout,
    input  logic [15:0]       wdata,
    output logic              mem_resp,
    output logic [15:0]       rdata,
    output logic              busy,
    output logic              proto_err
);

    localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam int BANK_W  = ADDR_W - 1;
    localparam logic [CNT_W-1:0] RD_LD = CNT_W'(READ_LAT - 1);
    localparam logic [CNT_W-1:0] WR_LD = CNT_W'(WRITE_LAT - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_is_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_wdata;
    logic [15:0]       r_rdata;
    logic              r_resp;
    logic              r_perr;

    logic [7:0] r_even [0:(1<<BANK_W)-1];
    logic [7:0] r_odd  [0:(1<<BANK_W)-1];

    logic              w_req_cap;
    logic              w_req_oth;
    logic              w_access;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr_hi;
    logic [BANK_W-1:0] w_even_idx;
    logic [BANK_W-1:0] w_odd_idx;
    logic [7:0]        w_even_d;
    logic [7:0]        w_odd_d;
    logic [7:0]        w_rbyte;

    assign w_req_cap = r_is_wr ? write_req : read_req;
    assign w_req_oth = r_is_wr ? read_req  : write_req;
    assign w_access  = (r_state == ST_WAIT) && w_req_cap && (r_cnt == '0);
    assign w_we      = w_access && r_is_wr;

    // addr and addr+1 always differ in parity; the wrap to 0 lands in the even bank
    assign w_addr_hi  = r_addr + 1'b1;
    assign w_odd_idx  = r_addr[ADDR_W-1:1];
    assign w_even_idx = r_addr[0] ? w_addr_hi[ADDR_W-1:1] : r_addr[ADDR_W-1:1];
    assign w_even_d   = r_addr[0] ? r_wdata[15:8] : r_wdata[7:0];
    assign w_odd_d    = r_addr[0] ? r_wdata[7:0]  : r_wdata[15:8];
    assign w_rbyte    = r_addr[0] ? r_odd[r_addr[ADDR_W-1:1]] : r_even[r_addr[ADDR_W-1:1]];

    // Contents survive reset; reset forces IDLE so an interrupted access never writes
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_even[w_even_idx] <= w_even_d;
            r_odd[w_odd_idx]   <= w_odd_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_is_wr <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_resp  <= 1'b0;
            r_perr  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (read_req && write_req) begin
                        r_perr <= 1'b1;
                    end else if (read_req || write_req) begin
                        r_is_wr <= write_req;
                        r_addr  <= addrout;
                        r_wdata <= wdata;
                        r_cnt   <= write_req ? WR_LD : RD_LD;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_req_oth) r_perr <= 1'b1;
                    if (!w_req_cap) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt == '0) begin
                        r_state <= ST_RESP;
                        r_resp  <= 1'b1;
                        if (!r_is_wr) r_rdata <= {8'h00, w_rbyte};
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (w_req_oth) r_perr <= 1'b1;
                    if (!w_req_cap) begin
                        r_state <= ST_IDLE;
                        r_resp  <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign mem_resp  = r_resp;
    assign rdata     = r_rdata;
    assign busy      = (r_state != ST_IDLE);
    assign proto_err = r_perr;

endmodule

// File: tb/tb_sys_mem_resp.sv
// Bench for sys_mem_resp: two instances (2/2 and 1/3 latencies) checked against a byte-map model.
module tb_sys_mem_resp;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        rd_req [2];
    logic        wr_req [2];
    logic [13:0] addr   [2];
    logic [15:0] wd     [2];
    logic        resp   [2];
    logic [15:0] rdat   [2];
    logic        bsy    [2];
    logic        perr   [2];

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  mdl [int];
    logic [15:0] last_rd [2];
    logic [13:0] pool [8] = '{14'h0000, 14'h0001, 14'h0100, 14'h0101,
                              14'h1235, 14'h2000, 14'h3FFE, 14'h3FFF};

    always #5 clk = ~clk;

    sys_mem_resp #(.ADDR_W(14), .READ_LAT(2), .WRITE_LAT(2)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .read_req(rd_req[0]), .write_req(wr_req[0]),
        .addrout(addr[0]), .wdata(wd[0]), .mem_resp(resp[0]), .rdata(rdat[0]),
        .busy(bsy[0]), .proto_err(perr[0]));

    sys_mem_resp #(.ADDR_W(14), .READ_LAT(1), .WRITE_LAT(3)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .read_req(rd_req[1]), .write_req(wr_req[1]),
        .addrout(addr[1]), .wdata(wd[1]), .mem_resp(resp[1]), .rdata(rdat[1]),
        .busy(bsy[1]), .proto_err(perr[1]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int key(input int d, input logic [13:0] a);
        return d * 65536 + int'(a);
    endfunction

    function automatic int lat(input int d, input bit w);
        if (d == 0) return 2;
        return w ? 3 : 1;
    endfunction

    function automatic logic [15:0] mdl_rd(input int d, input logic [13:0] a);
        if (!mdl.exists(key(d, a))) return 16'hxxxx;
        return {8'h00, mdl[key(d, a)]};
    endfunction

    // Starts on a negedge with the DUT idle, ends on the negedge after the request is seen low
    task automatic do_op(input int d, input bit w, input logic [13:0] a,
                         input logic [15:0] dat, input int hold);
        int cyc;
        logic [15:0] exp_rd;
        addr[d] = a;
        wd[d]   = dat;
        if (w) begin
            wr_req[d] = 1'b1;
            mdl[key(d, a)] = dat[7:0];
            mdl[key(d, a + 14'd1)] = dat[15:8];
            exp_rd = last_rd[d];
        end else begin
            rd_req[d] = 1'b1;
            exp_rd = mdl_rd(d, a);
        end
        @(posedge clk);
        @(negedge clk);
        addr[d] = 14'($urandom);
        wd[d]   = 16'($urandom);
        chk("busy_wait", {31'd0, bsy[d]}, 1);
        cyc = 0;
        while (!resp[d] && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk(w ? "wr_lat" : "rd_lat", cyc, lat(d, w));
        chk("rdata", {16'd0, rdat[d]}, {16'd0, exp_rd});
        repeat (hold) begin
            @(negedge clk);
            chk("hold_resp", {31'd0, resp[d]}, 1);
            chk("hold_rdata", {16'd0, rdat[d]}, {16'd0, exp_rd});
        end
        rd_req[d] = 1'b0;
        wr_req[d] = 1'b0;
        @(negedge clk);
        chk("resp_fall", {31'd0, resp[d]}, 0);
        chk("busy_fall", {31'd0, bsy[d]}, 0);
        last_rd[d] = exp_rd;
    endtask

    task automatic do_abort(input int d, input logic [13:0] a, input logic [15:0] dat);
        addr[d]   = a;
        wd[d]     = dat;
        wr_req[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wr_req[d] = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("abort_resp", {31'd0, resp[d]}, 0);
        end
        chk("abort_busy", {31'd0, bsy[d]}, 0);
    endtask

    task automatic chk_reset_outs(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_resp"}, {31'd0, resp[d]}, 0);
            chk({tag, "_rdata"}, {16'd0, rdat[d]}, 0);
            chk({tag, "_busy"}, {31'd0, bsy[d]}, 0);
            chk({tag, "_perr"}, {31'd0, perr[d]}, 0);
        end
    endtask

    initial begin
        int cyc;
        for (int d = 0; d < 2; d++) begin
            rd_req[d] = 1'b0; wr_req[d] = 1'b0; addr[d] = '0; wd[d] = '0; last_rd[d] = '0;
        end
        #1 reset_n = 1'b0;
        #1 chk_reset_outs("rst");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // directed: basic write/read and address wrap
        do_op(0, 1, 14'h0100, 16'hBEEF, 0);
        do_op(0, 0, 14'h0100, 16'h0, 0);
        chk("rd_ef", {16'd0, rdat[0]}, 32'h00EF);
        do_op(0, 0, 14'h0101, 16'h0, 0);
        chk("rd_be", {16'd0, rdat[0]}, 32'h00BE);
        do_op(0, 1, 14'h3FFF, 16'h1234, 1);
        do_op(0, 0, 14'h3FFF, 16'h0, 0);
        chk("wrap_lo", {16'd0, rdat[0]}, 32'h0034);
        do_op(0, 0, 14'h0000, 16'h0, 0);
        chk("wrap_hi", {16'd0, rdat[0]}, 32'h0012);
        do_op(0, 0, 14'h0100, 16'h0, 5);

        // fill the address pool then randomized traffic on both instances
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 8; i++) do_op(d, 1, pool[i], 16'($urandom), 0);
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 40; i++) begin
                bit w;
                logic [13:0] a;
                w = ($urandom_range(0, 1) == 1);
                a = pool[$urandom_range(0, 7)];
                if (w && $urandom_range(0, 3) == 0) a = 14'($urandom);
                do_op(d, w, a, 16'($urandom), $urandom_range(0, 3));
                if ($urandom_range(0, 2) == 0) @(negedge clk);
            end
        end
        chk("perr_clean0", {31'd0, perr[0]}, 0);
        chk("perr_clean1", {31'd0, perr[1]}, 0);

        // abort: no response, old contents kept
        do_abort(1, 14'h0100, 16'hDEAD);
        do_op(1, 0, 14'h0100, 16'h0, 0);
        do_op(1, 0, 14'h0101, 16'h0, 0);
        do_abort(0, 14'h1235, 16'hC0DE);
        do_op(0, 0, 14'h1235, 16'h0, 0);

        // both requests in IDLE
        rd_req[0] = 1'b1; wr_req[0] = 1'b1;
        @(negedge clk);
        chk("both_perr", {31'd0, perr[0]}, 1);
        chk("both_resp", {31'd0, resp[0]}, 0);
        chk("both_busy", {31'd0, bsy[0]}, 0);
        @(negedge clk);
        rd_req[0] = 1'b0; wr_req[0] = 1'b0;
        @(negedge clk);
        do_op(0, 0, 14'h0100, 16'h0, 1);
        chk("perr_sticky", {31'd0, perr[0]}, 1);

        // other op raised during WAIT is flagged and ignored
        addr[1] = 14'h2000; wd[1] = 16'h7788; wr_req[1] = 1'b1;
        mdl[key(1, 14'h2000)] = 8'h88;
        mdl[key(1, 14'h2001)] = 8'h77;
        @(posedge clk);
        @(negedge clk);
        rd_req[1] = 1'b1;
        @(negedge clk);
        rd_req[1] = 1'b0;
        cyc = 0;
        while (!resp[1] && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("oth_resp", {31'd0, resp[1]}, 1);
        chk("oth_perr", {31'd0, perr[1]}, 1);
        wr_req[1] = 1'b0;
        @(negedge clk);
        do_op(1, 0, 14'h2001, 16'h0, 0);

        // asynchronous reset in the middle of a write's WAIT
        do_op(0, 1, 14'h0100, 16'h5AA5, 0);
        do_op(0, 0, 14'h0100, 16'h0, 0);
        addr[0] = 14'h0100; wd[0] = 16'h1111; wr_req[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 chk_reset_outs("async_rst");
        wr_req[0] = 1'b0;
        last_rd[0] = '0;
        last_rd[1] = '0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        do_op(0, 0, 14'h0100, 16'h0, 0);
        chk("post_rst_val", {16'd0, rdat[0]}, 32'h00A5);
        do_op(1, 1, 14'h0000, 16'hABCD, 0);
        do_op(1, 0, 14'h0001, 16'h0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sys_mem_resp.md
# sys_mem_resp

System memory responder: 16 KByte byte-addressed storage that serves the processor's memory interface unit over the req/resp handshake. It accepts one read or write at a time, waits a fixed latency, then asserts `mem_resp` and holds it until the requester drops its request (four-phase). Writes store 2 bytes; reads return 1 byte. It sits at the far end of the memory interface as its synthesizable memory model.

## Interface
- `ADDR_W`, 14: byte address width; depth is 2^ADDR_W bytes.
- `READ_LAT`, 2: cycles from request acceptance to `mem_resp` for reads; must be at least 1.
- `WRITE_LAT`, 2: cycles from request acceptance to `mem_resp` for writes; must be at least 1.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `read_req`  in  1  read request, held high until `mem_resp` is seen.
- `write_req`  in  1  write request, held high until `mem_resp` is seen.
- `addrout`  in  ADDR_W  byte address from the requester.
- `wdata`  in  16  write data; `[7:0]` goes to addr, `[15:8]` goes to addr+1.
- `mem_resp`  out  1  response; high from completion until the request is dropped.
- `rdata`  out  16  read data; `[7:0]` = byte at addr, `[15:8]` = 0.
- `busy`  out  1  high in any state other than IDLE.
- `proto_err`  out  1  sticky; set on a protocol violation.

## Operation
- Reset values: `mem_resp`=0, `rdata`=0, `busy`=0, `proto_err`=0, state IDLE, counter 0.
- Reset does not clear memory contents. An access that reset interrupts leaves memory unchanged.
- States:
  - IDLE: samples the requests.
    - Exactly one request high: capture `addrout`, `wdata` and the op, load counter with LAT-1, go to WAIT.
    - Both high: set `proto_err`, accept nothing, stay IDLE.
  - WAIT: decrement the counter.
    - Counter at 0 and request still high: perform the access and go to RESP.
      - Write: mem[a] ← wdata[7:0], mem[(a+1) mod 2^ADDR_W] ← wdata[15:8].
      - Read: rdata ← {8'h00, mem[a]}.
    - Captured request drops while in WAIT: abort, no access, no `mem_resp`, back to IDLE.
  - RESP: `mem_resp`=1.
    - Captured request sampled low: go to IDLE, `mem_resp`=0.
- Address and data are captured only at acceptance. Changes on `addrout` or `wdata` after acceptance are ignored.
- A request for the other op raised during WAIT or RESP sets `proto_err` and is ignored.
- Address wrap: a write at 16383 (for ADDR_W=14) stores the high byte at address 0.
- `rdata` holds its last read value until the next read completes. Writes do not change `rdata`.

## Timing
- Request sampled high at edge N (IDLE→WAIT). Access and `mem_resp` rise take effect at edge N+LAT.
- For LAT=1, `mem_resp` is high the cycle after acceptance.
- `rdata` is valid in the same cycle `mem_resp` rises and stays stable while `mem_resp` is high.
- Requester drops its request, and it is sampled low at edge M: `mem_resp` is 0 after edge M and the state is IDLE.
- A new request sampled at edge M+1 is accepted. Minimum transaction spacing is LAT+2 cycles.
- The write is visible to a read accepted at any edge after the write's `mem_resp` rises.
- `reset_n` low takes effect immediately, without a clock edge: all outputs go to their reset values and the state returns to IDLE, including mid-WAIT or mid-RESP.

## Test plan
- Write then read, READ_LAT=WRITE_LAT=2:
  - Write addr 0x0100, wdata 0xBEEF → `mem_resp` high 2 cycles after acceptance.
  - Then read 0x0100 → `rdata`=0x00EF; read 0x0101 → `rdata`=0x00BE.
- Wrap: write 0x3FFF with 0x1234 → read 0x3FFF returns 0x0034; read 0x0000 returns 0x0012.
- Handshake hold: requester keeps `read_req` high 5 cycles past `mem_resp` → `mem_resp` stays high all 5 cycles, falls the cycle after `read_req` is sampled low, `busy` falls with it.
- Abort: `write_req` dropped 1 cycle after acceptance with WRITE_LAT=3 → no `mem_resp`; a later read of that address returns the old contents.
- Both requests high in IDLE → `proto_err`=1, `mem_resp` stays 0, `busy` stays 0. `proto_err` stays 1 until reset.
- Reset mid-operation: assert `reset_n`=0 asynchronously during WAIT → all outputs 0 immediately. After release, a read of a previously written address returns its pre-reset value.
